usb_crc16_check: RTL and testbench

Receive-side CRC16 checker for USB data packets. Consumes the byte stream after PID stripping and computes the USB CRC16 over payload plus the two trailing CRC bytes. At end of packet it flags pass or fail against the fixed residual and reports packet length. Sits between the receive byte assembler and the receive FIFO, mirroring the transmit-side `usb_crc16` generator.

---
 rtl/usb_crc16_check.sv | 105 ++++++++++
 tb/tb_usb_crc16_check.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_crc16_check.sv
// Receive-side USB CRC16 checker: running reflected CRC, end-of-packet residual/length status.
// Optional payload strip (drops the two trailing CRC bytes) is built when USB_CRC16_STRIP_EN is defined.
module usb_crc16_check (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_start,
  input  logic        in_last,
  output logic [15:0] crc_out,
  output logic        crc_done,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        len_err,
  output logic [10:0] byte_cnt,
  output logic [7:0]  pay_data,
  output logic        pay_valid
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

  state_t      state, state_next;
  logic        accept;
  logic [15:0] crc_next;
  logic [10:0] cnt_next;
  logic        resid_match;
  logic        len_bad;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // A start byte is taken in any state (restart/abort); other bytes only while a packet is open.
  always_comb begin
    state_next  = state;
    crc_done    = 1'b0;
    accept      = in_valid && (in_start || state == RUN);
    crc_next    = crc_byte(in_start ? 16'hFFFF : crc_out, in_data);
    cnt_next    = in_start ? 11'd1 : ((byte_cnt == '1) ? byte_cnt : byte_cnt + 11'd1);
    resid_match = (crc_next == 16'hB001);
    len_bad     = (cnt_next < 11'd2) || (cnt_next > 11'd1026);
    if (state == CHECK) crc_done = 1'b1;
    if (accept)               state_next = in_last ? CHECK : RUN;
    else if (state == CHECK)  state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      crc_out  <= 16'hFFFF;
      byte_cnt <= '0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        crc_out  <= crc_next;
        byte_cnt <= cnt_next;
        // Status is registered on the last byte so it is valid alongside crc_done.
        if (in_last) begin
          crc_ok  <= resid_match && !len_bad;
          crc_err <= !resid_match;
          len_err <= len_bad;
        end else if (in_start) begin
          crc_ok  <= 1'b0;
          crc_err <= 1'b0;
          len_err <= 1'b0;
        end
      end
    end
  end

`ifdef USB_CRC16_STRIP_EN
  logic [7:0] hold0, hold1;

  // Two-byte delay line: whatever is still held when the packet ends is the CRC and is never emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold0     <= '0;
      hold1     <= '0;
      pay_data  <= '0;
      pay_valid <= 1'b0;
    end else begin
      pay_valid <= 1'b0;
      if (accept) begin
        hold0     <= in_data;
        hold1     <= hold0;
        pay_data  <= hold1;
        pay_valid <= (cnt_next >= 11'd3);
      end
    end
  end
`else
  assign pay_data  = '0;
  assign pay_valid = 1'b0;
`endif

endmodule

// File: tb/tb_usb_crc16_check.sv
// Self-checking bench for usb_crc16_check: directed spec packets plus randomized packets vs a table-driven CRC model.
module tb_usb_crc16_check;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_start, in_last;
  logic [15:0] crc_out;
  logic        crc_done, crc_ok, crc_err, len_err;
  logic [10:0] byte_cnt;
  logic [7:0]  pay_data;
  logic        pay_valid;

  usb_crc16_check dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_start(in_start),
    .in_last(in_last), .crc_out(crc_out), .crc_done(crc_done), .crc_ok(crc_ok),
    .crc_err(crc_err), .len_err(len_err), .byte_cnt(byte_cnt), .pay_data(pay_data),
    .pay_valid(pay_valid)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  int          done_seen = 0;
  int          exp_done = 0;
  logic [7:0]  act_pay[$];
  logic [7:0]  exp_pay[$];
  logic [15:0] tbl[256];
  logic        exp_ok, exp_err, exp_len;
  logic [10:0] exp_cnt;
  logic [15:0] exp_crc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [7:0] idx;
    idx = c[7:0] ^ d;
    return (c >> 8) ^ tbl[idx];
  endfunction

  function automatic logic [15:0] ref_crc(input bq_t b, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) c = crc_step(c, b[i]);
    return c;
  endfunction

  // Payload followed by its complemented CRC (low byte first); optionally one bit flipped.
  function automatic bq_t make_pkt(input int plen, input bit good);
    bq_t         q;
    logic [15:0] c;
    int          k;
    for (int i = 0; i < plen; i++) q.push_back(8'($urandom));
    c = ~ref_crc(q, plen);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    if (!good) begin
      k = $urandom_range(0, q.size() - 1);
      q[k] = q[k] ^ (8'h01 << $urandom_range(0, 7));
    end
    return q;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (crc_done) done_seen++;
      if (pay_valid) act_pay.push_back(pay_data);
    end
  end

  // Packet is good when its last two bytes equal the complemented CRC of everything before them.
  task automatic judge(input bq_t b);
    int   n;
    logic match;
    logic [15:0] pc;
    n = b.size();
    if (n >= 2) begin
      pc = ~ref_crc(b, n - 2);
      match = ({b[n-1], b[n-2]} == pc);
    end else begin
      match = (ref_crc(b, n) == 16'hB001);
    end
    exp_len = (n < 2) || (n > 1026);
    exp_err = !match;
    exp_ok  = match && !exp_len;
    exp_cnt = (n > 2047) ? 11'd2047 : 11'(n);
  endtask

  task automatic send_pkt(input bq_t b, input int gaps, input bit do_last, input bit chained);
    logic [15:0] c;
    int g;
    c = 16'hFFFF;
    for (int i = 0; i < b.size(); i++) begin
      if (!(chained && i == 0)) begin
        g = (gaps > 0) ? $urandom_range(0, gaps) : 0;
        repeat (g) begin
          @(negedge clk);
          if (i > 0) check("crc_hold", crc_out, c);
          in_valid = 1'b0;
          in_start = 1'($urandom_range(0, 1));
          in_last  = 1'($urandom_range(0, 1));
          in_data  = 8'($urandom);
        end
        @(negedge clk);
      end
      if (i > 0) check("crc_run", crc_out, c);
      in_valid = 1'b1;
      in_data  = b[i];
      in_start = (i == 0);
      in_last  = do_last && (i == b.size() - 1);
`ifdef USB_CRC16_STRIP_EN
      if (i >= 2) exp_pay.push_back(b[i-2]);
`endif
      c = crc_step(c, b[i]);
      exp_cnt = (i + 1 > 2047) ? 11'd2047 : 11'(i + 1);
      if (i == 0) begin
        exp_ok = 1'b0; exp_err = 1'b0; exp_len = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0;
    exp_crc = c;
    if (do_last) begin
      exp_done++;
      judge(b);
      check("crc_done", crc_done, 1);
      check("crc_ok", crc_ok, exp_ok);
      check("crc_err", crc_err, exp_err);
      check("len_err", len_err, exp_len);
      check("byte_cnt", byte_cnt, exp_cnt);
      check("crc_final", crc_out, c);
    end
  endtask

  task automatic sync;
    int n;
    @(negedge clk);
    #1;
    check("done_low", crc_done, 0);
    check("ok_hold", crc_ok, exp_ok);
    check("err_hold", crc_err, exp_err);
    check("len_hold", len_err, exp_len);
    check("cnt_hold", byte_cnt, exp_cnt);
    check("crc_hold", crc_out, exp_crc);
    check("done_cnt", done_seen, exp_done);
    check("pay_cnt", act_pay.size(), exp_pay.size());
    n = (act_pay.size() < exp_pay.size()) ? act_pay.size() : exp_pay.size();
    for (int i = 0; i < n; i++) check("pay_data", act_pay[i], exp_pay[i]);
    act_pay.delete();
    exp_pay.delete();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0;
    repeat (cycles - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_crc", crc_out, 16'hFFFF);
    check("rst_done", crc_done, 0);
    check("rst_ok", crc_ok, 0);
    check("rst_err", crc_err, 0);
    check("rst_len", len_err, 0);
    check("rst_cnt", byte_cnt, 0);
    check("rst_pvalid", pay_valid, 0);
    check("rst_pdata", pay_data, 0);
    exp_ok = 1'b0; exp_err = 1'b0; exp_len = 1'b0; exp_cnt = '0; exp_crc = 16'hFFFF;
  endtask

  initial begin
    bq_t b;
    bit  chn, abort;
    logic [15:0] c;

    for (int i = 0; i < 256; i++) begin
      c = 16'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      tbl[i] = c;
    end
    rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_last = 1'b0; in_data = '0;
    do_reset(3);

    b = '{8'h00, 8'h00};               send_pkt(b, 0, 1, 0); sync;
    b = '{8'h00, 8'h40, 8'hBF};        send_pkt(b, 0, 1, 0); sync;
    check("resid", crc_out, 16'hB001);
    b = '{8'h00, 8'h40, 8'hBE};        send_pkt(b, 1, 1, 0); sync;
    b = '{8'hA5};                      send_pkt(b, 0, 1, 0); sync;

    b = '{8'h11, 8'h22, 8'h33};        send_pkt(b, 0, 0, 0);
    b = '{8'h00, 8'h40, 8'hBF};        send_pkt(b, 0, 1, 0); sync;

    b = '{8'h12, 8'h34};               send_pkt(b, 0, 0, 0);
    do_reset(1);
    b = '{8'h00, 8'h40, 8'hBF};        send_pkt(b, 0, 1, 0); sync;

    b = make_pkt(5, 1);                send_pkt(b, 0, 1, 0);
    b = make_pkt(4, 1);                send_pkt(b, 0, 1, 1); sync;

    b = make_pkt(1025, 1);             send_pkt(b, 0, 1, 0); sync;
    b = make_pkt(1024, 1);             send_pkt(b, 0, 1, 0); sync;
    b = make_pkt(2048, 0);             send_pkt(b, 0, 1, 0); sync;

    chn = 1'b0;
    for (int k = 0; k < 40; k++) begin
      abort = ($urandom_range(0, 7) == 0);
      b = make_pkt($urandom_range(0, 20), $urandom_range(0, 9) < 7);
      send_pkt(b, 2, !abort, chn);
      chn = !abort && ($urandom_range(0, 3) == 0);
      if (!chn) sync;
    end
    if (chn) sync;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
